// File: rtl/tower_sprite_memory_pkg.sv
// -----------------------------------------------------------------------------
// tower_pkg
// Shared constants and types for the tower sprite storage/addressing slice of
// the 160x120 VGA game.
//   - Sprite and screen geometry (pixels).
//   - Coordinate and address widths derived from that geometry.
//   - Colour word type: 3 bits each of R, G, B.
// -----------------------------------------------------------------------------
package tower_pkg;

    localparam int SPRITE_W  = 20;
    localparam int SPRITE_H  = 20;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int COLOUR_W  = 9;

    // Coordinate widths are fixed by the sequencer's counters, not by the
    // geometry, so out-of-range coordinates are representable.
    localparam int SPRITE_XW = 5;
    localparam int SPRITE_YW = 5;
    localparam int SCREEN_XW = 8;
    localparam int SCREEN_YW = 7;

    // Linear address widths: 400 sprite entries, 19200 screen pixels.
    localparam int SPRITE_AW = 9;
    localparam int SCREEN_AW = 15;

    localparam int SPRITE_DEPTH = SPRITE_W * SPRITE_H;

    typedef logic [COLOUR_W-1:0] colour_t;

endpackage : tower_pkg

// File: rtl/tower_sprite_memory_if.sv
// -----------------------------------------------------------------------------
// tower_sprite_memory_if
// Bus between the tower-drawing sequencer (master) and the sprite memory unit
// (slave).
//   sprite_x/sprite_y   : sprite-local coordinate, selects the RAM entry
//   sprite_addr         : linear sprite address, sprite_in_range flag
//   screen_x/screen_y   : screen coordinate to translate
//   screen_addr         : linear frame-buffer address, screen_in_range flag
//   wren/wdata          : sprite RAM write port
//   q                   : registered read colour
// -----------------------------------------------------------------------------
interface tower_sprite_memory_if;
    import tower_pkg::*;

    logic [SPRITE_XW-1:0] sprite_x;
    logic [SPRITE_YW-1:0] sprite_y;
    logic [SPRITE_AW-1:0] sprite_addr;
    logic                 sprite_in_range;

    logic [SCREEN_XW-1:0] screen_x;
    logic [SCREEN_YW-1:0] screen_y;
    logic [SCREEN_AW-1:0] screen_addr;
    logic                 screen_in_range;

    logic                 wren;
    colour_t              wdata;
    colour_t              q;

    modport master (
        output sprite_x, sprite_y, screen_x, screen_y, wren, wdata,
        input  sprite_addr, sprite_in_range, screen_addr, screen_in_range, q
    );

    modport slave (
        input  sprite_x, sprite_y, screen_x, screen_y, wren, wdata,
        output sprite_addr, sprite_in_range, screen_addr, screen_in_range, q
    );

endinterface : tower_sprite_memory_if

// File: rtl/tower_sprite_memory_address_translator.sv
// -----------------------------------------------------------------------------
// address_translator
// Purely combinational (x, y) -> y*W + x translation with a range flag.
//   x        in  XW : column
//   y        in  YW : row
//   addr     out AW : y*W + x, computed at full width then truncated to AW
//   in_range out 1  : x < W and y < H
// Out-of-range coordinates still produce the truncated address; only the
// flag tells the caller not to trust it.
// -----------------------------------------------------------------------------
module address_translator #(
    parameter int W  = 20,
    parameter int H  = 20,
    parameter int XW = 5,
    parameter int YW = 5,
    parameter int AW = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          in_range
);

    // Wide enough that y*W + x never overflows for any representable input.
    localparam int FW = XW + YW + $clog2(W + 1) + 1;

    // Full-width linear address, truncated to the output width, plus range test.
    always_comb begin
        addr     = AW'(FW'(y) * FW'(W) + FW'(x));
        in_range = (int'(x) < W) && (int'(y) < H);
    end

endmodule : address_translator

// File: rtl/tower_sprite_memory.sv
// -----------------------------------------------------------------------------
// tower_sprite_memory
// Storage and addressing unit for the 20x20 tower sprite.
//   clk     in : clock
//   resetn  in : synchronous, active-low reset (clears q, blocks writes,
//                leaves RAM contents untouched)
//   bus        : tower_sprite_memory_if.slave
//                - sprite/screen coordinate translators (combinational)
//                - 400 x 9 single-port RAM, write-first, 1-cycle read into q
// Out-of-range sprite coordinates read as 0 and never write the RAM.
// -----------------------------------------------------------------------------
module tower_sprite_memory
    import tower_pkg::*;
#(
    parameter int    SPRITE_W  = tower_pkg::SPRITE_W,
    parameter int    SPRITE_H  = tower_pkg::SPRITE_H,
    parameter int    SCREEN_W  = tower_pkg::SCREEN_W,
    parameter int    SCREEN_H  = tower_pkg::SCREEN_H,
    parameter int    COLOUR_W  = tower_pkg::COLOUR_W,
    parameter string INIT_FILE = "tower.mif"
) (
    input  logic                  clk,
    input  logic                  resetn,
    tower_sprite_memory_if.slave  bus
);

    localparam int DEPTH = SPRITE_W * SPRITE_H;

    logic [SPRITE_AW-1:0] sprite_addr_s;
    logic                 sprite_in_range_s;

    // Image is preloaded by the FPGA configuration, not by logic.
    (* ram_init_file = INIT_FILE *)
    logic [COLOUR_W-1:0]  mem_r [0:DEPTH-1];
    logic [COLOUR_W-1:0]  q_r;

    address_translator #(
        .W  (SPRITE_W),
        .H  (SPRITE_H),
        .XW (SPRITE_XW),
        .YW (SPRITE_YW),
        .AW (SPRITE_AW)
    ) u_sprite_xlate (
        .x        (bus.sprite_x),
        .y        (bus.sprite_y),
        .addr     (sprite_addr_s),
        .in_range (sprite_in_range_s)
    );

    address_translator #(
        .W  (SCREEN_W),
        .H  (SCREEN_H),
        .XW (SCREEN_XW),
        .YW (SCREEN_YW),
        .AW (SCREEN_AW)
    ) u_screen_xlate (
        .x        (bus.screen_x),
        .y        (bus.screen_y),
        .addr     (bus.screen_addr),
        .in_range (bus.screen_in_range)
    );

    assign bus.sprite_addr     = sprite_addr_s;
    assign bus.sprite_in_range = sprite_in_range_s;
    assign bus.q               = q_r;

    // RAM write port: only in-range writes outside reset reach the array.
    always_ff @(posedge clk) begin
        if (resetn && bus.wren && sprite_in_range_s) begin
            mem_r[sprite_addr_s] <= bus.wdata;
        end
    end

    // Registered read: write-first on a colliding write, 0 when out of range.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_r <= {COLOUR_W{1'b0}};
        end else if (!sprite_in_range_s) begin
            q_r <= {COLOUR_W{1'b0}};
        end else if (bus.wren) begin
            q_r <= bus.wdata;
        end else begin
            q_r <= mem_r[sprite_addr_s];
        end
    end

endmodule : tower_sprite_memory

// File: tb/tb_tower_sprite_memory.sv
// -----------------------------------------------------------------------------
// tb_tower_sprite_memory
// Self-checking bench: table-driven translator vectors, then a reference
// image model with a queue of expected q values for the RAM sequences.
// -----------------------------------------------------------------------------
module tb_tower_sprite_memory;

    logic clk;
    logic resetn;

    tower_sprite_memory_if bus ();

    tower_sprite_memory #(
        .SPRITE_W  (20),
        .SPRITE_H  (20),
        .SCREEN_W  (160),
        .SCREEN_H  (120),
        .COLOUR_W  (9),
        .INIT_FILE ("tower.mif")
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] img [0:399];
    logic [8:0] exp_q [$];

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [14:0] addr;
        logic        inr;
    } vec_t;

    vec_t spr_tab [7];
    vec_t scr_tab [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic set_sprite(input int x, input int y, input logic we, input logic [8:0] wd);
        bus.sprite_x = 5'(x);
        bus.sprite_y = 5'(y);
        bus.wren     = we;
        bus.wdata    = wd;
    endtask

    // One clock: predict q from the current inputs, advance, compare.
    task automatic step(input string name);
        int         a;
        bit         inr;
        logic [8:0] e;
        logic [8:0] w;
        inr = (int'(bus.sprite_x) < 20) && (int'(bus.sprite_y) < 20);
        a   = (int'(bus.sprite_y) * 20 + int'(bus.sprite_x)) % 512;
        if (!resetn || !inr) begin
            e = 9'd0;
        end else if (bus.wren) begin
            e      = bus.wdata;
            img[a] = bus.wdata;
        end else begin
            e = img[a];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        w = exp_q.pop_front();
        check(name, 32'(bus.q), 32'(w));
    endtask

    task automatic sweep(input int from, input int to, input string name);
        for (int k = from; k < to; k++) begin
            set_sprite(k % 20, k / 20, 1'b0, 9'd0);
            step(name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        spr_tab[0] = '{8'd0,  7'd0,  15'd0,   1'b1};
        spr_tab[1] = '{8'd19, 7'd0,  15'd19,  1'b1};
        spr_tab[2] = '{8'd0,  7'd1,  15'd20,  1'b1};
        spr_tab[3] = '{8'd19, 7'd19, 15'd399, 1'b1};
        spr_tab[4] = '{8'd20, 7'd0,  15'd20,  1'b0};
        spr_tab[5] = '{8'd3,  7'd2,  15'd43,  1'b1};
        spr_tab[6] = '{8'd31, 7'd31, 15'd139, 1'b0};   // 651 truncated to 9 bits

        scr_tab[0] = '{8'd0,   7'd0,   15'd0,     1'b1};
        scr_tab[1] = '{8'd159, 7'd0,   15'd159,   1'b1};
        scr_tab[2] = '{8'd0,   7'd1,   15'd160,   1'b1};
        scr_tab[3] = '{8'd159, 7'd119, 15'd19199, 1'b1};
        scr_tab[4] = '{8'd160, 7'd5,   15'd960,   1'b0};
        scr_tab[5] = '{8'd0,   7'd120, 15'd19200, 1'b0};

        resetn       = 1'b0;
        bus.screen_x = 8'd0;
        bus.screen_y = 7'd0;
        set_sprite(0, 0, 1'b0, 9'd0);

        // Reset state
        step("reset_q0");
        step("reset_q1");

        // Combinational translators follow inputs even during reset
        for (int i = 0; i < 7; i++) begin
            bus.sprite_x = spr_tab[i].x[4:0];
            bus.sprite_y = spr_tab[i].y[4:0];
            #1;
            check($sformatf("sprite_addr[%0d]", i), 32'(bus.sprite_addr), 32'(spr_tab[i].addr[8:0]));
            check($sformatf("sprite_in_range[%0d]", i), 32'(bus.sprite_in_range), 32'(spr_tab[i].inr));
        end
        for (int i = 0; i < 6; i++) begin
            bus.screen_x = scr_tab[i].x;
            bus.screen_y = scr_tab[i].y;
            #1;
            check($sformatf("screen_addr[%0d]", i), 32'(bus.screen_addr), 32'(scr_tab[i].addr));
            check($sformatf("screen_in_range[%0d]", i), 32'(bus.screen_in_range), 32'(scr_tab[i].inr));
        end

        @(negedge clk);
        resetn = 1'b1;

        // Load a known image through the write port (write-first on q)
        for (int k = 0; k < 400; k++) begin
            set_sprite(k % 20, k / 20, 1'b1, 9'((k * 37 + 5) & 511));
            step("load_write_first");
        end

        // Read latency at (3,2) -> entry 43
        set_sprite(3, 2, 1'b0, 9'd0);
        step("read_43");

        // Full sweep returns the image in order
        sweep(0, 400, "sweep_full");

        // Write then read at (5,5) -> entry 105
        set_sprite(5, 5, 1'b1, 9'h1FF);
        step("rw_same_addr");
        set_sprite(5, 5, 1'b0, 9'd0);
        step("read_after_write");

        // Out-of-range write is ignored and reads 0
        set_sprite(25, 3, 1'b1, 9'h0AA);
        step("oor_write_q0");

        // Reset mid-sweep, with writes attempted during reset
        sweep(0, 50, "sweep_pre_reset");
        resetn = 1'b0;
        set_sprite(0, 0, 1'b1, 9'h055);
        step("midreset_q0");
        set_sprite(1, 0, 1'b1, 9'h066);
        step("midreset_q1");
        resetn = 1'b1;
        sweep(50, 400, "sweep_post_reset");

        // Everything (entry 85 untouched by the out-of-range write, entries 0/1
        // untouched by reset writes, 105 = 1FF) confirmed by a final sweep
        sweep(0, 400, "sweep_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tower_sprite_memory
